// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI bus arbiter.
//   arb_state_t      : arbiter FSM states
//   N_MASTERS_DEF    : default number of REQ/GNT pairs
//   GNT_TIMEOUT_DEF  : default cycles an unused grant is held
//   ASSERTED/DEASSERTED : levels of the active-low bus signals
package pci_arb_pkg;

    localparam int unsigned N_MASTERS_DEF   = 3;
    localparam int unsigned GNT_TIMEOUT_DEF = 16;

    localparam logic ASSERTED   = 1'b0;
    localparam logic DEASSERTED = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BUSY  = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/pci_bus_arbiter_if.sv
// Arbiter-side view of the shared PCI bus.
//   REQ/FRAME/IRDY : active-low inputs to the arbiter
//   GNT            : active-low per-master grant
//   owner          : current or last granted master
//   bus_busy       : a grant is outstanding or a transaction is running
//   timeout_pulse  : one-cycle flag when an unused grant is reclaimed
// Modport master is the arbiter, slave is the device/bus side.
interface pci_bus_arbiter_if #(
    parameter int unsigned N_MASTERS = pci_arb_pkg::N_MASTERS_DEF,
    parameter int unsigned IDX_W     = $clog2(N_MASTERS)
);

    logic [N_MASTERS-1:0] REQ;
    logic                 FRAME;
    logic                 IRDY;
    logic [N_MASTERS-1:0] GNT;
    logic [IDX_W-1:0]     owner;
    logic                 bus_busy;
    logic                 timeout_pulse;

    modport master (
        input  REQ, FRAME, IRDY,
        output GNT, owner, bus_busy, timeout_pulse
    );

    modport slave (
        output REQ, FRAME, IRDY,
        input  GNT, owner, bus_busy, timeout_pulse
    );

endinterface

// File: rtl/pci_rr_select.sv
// Round-robin winner select, purely combinational.
//   req_i    : active-high request vector
//   rr_ptr_i : highest-priority index this round (must be < N_MASTERS)
//   valid_o  : at least one request present
//   winner_o : first requesting index at rr_ptr, rr_ptr+1, ... (wrapping)
module pci_rr_select #(
    parameter int unsigned N_MASTERS = 3,
    parameter int unsigned IDX_W     = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req_i,
    input  logic [IDX_W-1:0]     rr_ptr_i,
    output logic                 valid_o,
    output logic [IDX_W-1:0]     winner_o
);

    // one extra bit so rr_ptr + offset never overflows before the explicit wrap
    localparam int unsigned SUM_W = IDX_W + 1;

    always_comb begin
        logic [SUM_W-1:0] idx;
        valid_o  = 1'b0;
        winner_o = '0;
        idx      = '0;
        // walk from the farthest offset inward so the closest requester wins last
        for (int off = int'(N_MASTERS) - 1; off >= 0; off--) begin
            idx = SUM_W'(rr_ptr_i) + SUM_W'(off);
            if (idx >= SUM_W'(N_MASTERS)) begin
                idx = idx - SUM_W'(N_MASTERS);
            end
            if (req_i[IDX_W'(idx)]) begin
                valid_o  = 1'b1;
                winner_o = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central round-robin PCI arbiter.
//   clk, rst : bus clock, synchronous active-high reset
//   bus      : pci_bus_arbiter_if.master (REQ/FRAME/IRDY in, GNT/owner/
//              bus_busy/timeout_pulse out, all outputs registered)
// Optional bus parking is compiled in with PCI_ARB_BUS_PARK_EN.
module pci_bus_arbiter
    import pci_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS   = N_MASTERS_DEF,
    parameter int unsigned GNT_TIMEOUT = GNT_TIMEOUT_DEF,
    parameter int unsigned IDX_W       = $clog2(N_MASTERS)
) (
    input  logic              clk,
    input  logic              rst,
    pci_bus_arbiter_if.master bus
);

    localparam int unsigned          TMO_W    = $clog2(GNT_TIMEOUT);
    localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(GNT_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]     TMO_MAX  = '1;
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(N_MASTERS - 1);
    localparam logic [N_MASTERS-1:0] GNT_NONE = '1;

    arb_state_t           state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 tmo_pulse_q, tmo_pulse_d;
    logic                 busy_q, busy_d;
    logic [N_MASTERS-1:0] req_q;

    logic                 arb_valid;
    logic [IDX_W-1:0]     winner;
    logic [IDX_W-1:0]     next_owner;
    logic                 bus_idle;
    logic                 frame_low;
    logic                 owner_req;

    assign bus_idle   = (bus.FRAME == DEASSERTED) && (bus.IRDY == DEASSERTED);
    assign frame_low  = (bus.FRAME == ASSERTED);
    // only the owner's REQ bit is looked at while a grant is out
    assign owner_req  = (bus.REQ[owner_q] == ASSERTED);
    assign next_owner = (owner_q == IDX_LAST) ? '0 : owner_q + IDX_W'(1);

`ifdef PCI_ARB_BUS_PARK_EN
    logic parked;
    assign parked = (state_q == IDLE) && (gnt_q != GNT_NONE);
`endif

    // arbitration works on the request vector sampled one edge earlier
    pci_rr_select #(
        .N_MASTERS (N_MASTERS),
        .IDX_W     (IDX_W)
    ) u_rr_select (
        .req_i    (req_q),
        .rr_ptr_i (rr_ptr_q),
        .valid_o  (arb_valid),
        .winner_o (winner)
    );

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_q       <= GNT_NONE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            tmo_q       <= '0;
            tmo_pulse_q <= 1'b0;
            busy_q      <= 1'b0;
            req_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            tmo_q       <= tmo_d;
            tmo_pulse_q <= tmo_pulse_d;
            busy_q      <= busy_d;
            req_q       <= ~bus.REQ;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (arb_valid && bus_idle) begin
`ifdef PCI_ARB_BUS_PARK_EN
                    // a parked grant is released for one cycle before the new grant
                    if (!parked) begin
                        state_d = GRANT;
                    end
`else
                    state_d = GRANT;
`endif
                end
`ifdef PCI_ARB_BUS_PARK_EN
                else if (parked && frame_low) begin
                    state_d = BUSY;
                end
`endif
            end
            GRANT: begin
                if (frame_low) begin
                    state_d = BUSY;
                end else if (!owner_req) begin
                    state_d = TURN;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = TURN;
                end
            end
            BUSY: begin
                if (bus_idle) begin
                    state_d = TURN;
                end
            end
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // next values of the registered outputs and counters
    always_comb begin
        gnt_d       = GNT_NONE;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        tmo_d       = tmo_q;
        tmo_pulse_d = 1'b0;
        busy_d      = (state_d == GRANT) || (state_d == BUSY);
        unique case (state_q)
            IDLE: begin
                if (state_d == GRANT) begin
                    gnt_d[winner] = ASSERTED;
                    owner_d       = winner;
                    tmo_d         = '0;
                end
`ifdef PCI_ARB_BUS_PARK_EN
                else if (state_d == BUSY) begin
                    rr_ptr_d = next_owner;
                end else if (!arb_valid && bus_idle) begin
                    gnt_d[owner_q] = ASSERTED;
                end
`endif
            end
            GRANT: begin
                if (state_d == GRANT) begin
                    gnt_d[owner_q] = ASSERTED;
                    if (tmo_q != TMO_MAX) begin
                        tmo_d = tmo_q + TMO_W'(1);
                    end
                end else if (state_d == BUSY) begin
                    rr_ptr_d = next_owner;
                end else if (owner_req) begin
                    // left GRANT with the request still held: grant timed out
                    tmo_pulse_d = 1'b1;
                    rr_ptr_d    = next_owner;
                end
            end
            default: begin
            end
        endcase
    end

    assign bus.GNT           = gnt_q;
    assign bus.owner         = owner_q;
    assign bus.bus_busy      = busy_q;
    assign bus.timeout_pulse = tmo_pulse_q;

endmodule
